// File: rtl/sram_mem_controller.sv
// Sequences a 32-bit MEM-stage load/store onto a 16-bit async SRAM as two half-word phases.
// Latency: request in IDLE cycle 0 -> ready pulse in cycle 2*(WAIT_CYCLES+1)+1.
// Backpressure: freeze stalls the pipeline while a request is pending and not yet complete.
//
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   mem_read, mem_write    - MEM-stage load/store strobes, held stable while freeze=1
//   address, write_data    - byte address from the ALU and store data
//   read_data, ready       - load result and one-cycle completion pulse
//   freeze                 - pipeline stall
//   sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n - SRAM pins (tri-state lives at top level)
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata;
    logic [31:0]        eff;
    logic               req;
    logic               phase_end;
    logic               unused_bits;

    assign req       = mem_read | mem_write;
    assign eff       = address - 32'(BASE_ADDR);
    // Byte offset and bits above the SRAM range play no part in the mapping.
    assign unused_bits = ^{eff[31:SRAM_AW+1], eff[1:0]};
    assign phase_end = (cnt == LAST_CNT);
    assign ready     = (state == DONE);
    assign freeze    = req & ~ready;

    // Next-state and phase counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // SRAM pin drive; idle everywhere outside the two data phases
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (state == LOW || state == HIGH) begin
            sram_addr = {word, (state == HIGH)};
            if (op_wr) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
                // we_n rises on the last phase cycle so the SRAM latches stable data
                sram_we_n   = phase_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            word      <= '0;
            wdata     <= 32'h0;
            read_data <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                op_wr <= mem_write;   // write wins when both strobes are set
                word  <= eff[SRAM_AW:2];
                wdata <= write_data;
            end
            if (!op_wr && phase_end) begin
                if (state == LOW)
                    read_data[15:0]  <= sram_dq_in;
                else if (state == HIGH)
                    read_data[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller against an SRAM model and a transaction-level reference.
// Latency: checks every cycle of each transfer against the expected phase timing.
// Backpressure: requests are held for the full transfer and released after the ready cycle.
module tb_sram_mem_controller;

    localparam int          W    = 2;
    localparam int          P    = W + 1;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [31:0]   address = 32'h0;
    logic [31:0]   write_data = 32'h0;
    logic [31:0]   read_data;
    logic          ready;
    logic          freeze;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    always #5 clk = ~clk;

    sram_mem_controller #(
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .freeze      (freeze),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    // SRAM model: a write commits when we_n returns high with the same address still driven.
    logic [15:0]   sram_mem [0:(1<<AW)-1];
    logic [15:0]   exp_mem  [0:(1<<AW)-1];
    logic          pend = 1'b0;
    logic [AW-1:0] pend_a;
    logic [15:0]   pend_d;

    assign sram_dq_in = sram_mem[sram_addr];

    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            pend   = 1'b1;
            pend_a = sram_addr;
            pend_d = sram_dq_out;
        end else if (pend) begin
            if (sram_we_n && sram_dq_oe && sram_addr == pend_a)
                sram_mem[pend_a] = pend_d;
            pend = 1'b0;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rd = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Half-word address from the mapping rule: (byte address - base) / 4, folded into the SRAM range.
    function automatic logic [AW-1:0] half_addr(input logic [31:0] a, input bit hi);
        logic [31:0] eff;
        longint      w;
        eff = a - BASE;
        w   = longint'(eff >> 2) % (longint'(1) << (AW - 1));
        return AW'(w * 2 + longint'(hi));
    endfunction

    // Called one step after a rising edge of an IDLE cycle; returns likewise one cycle after ready.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] lo, hi;
        lo = half_addr(a, 1'b0);
        hi = half_addr(a, 1'b1);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        @(negedge clk);
        check("freeze_req", freeze, 1);
        check("ready_req", ready, 0);
        for (int k = 0; k < 2 * P; k++) begin
            int ph;
            int j;
            ph = k / P;
            j  = k % P;
            @(negedge clk);
            check("sram_addr", sram_addr, (ph != 0) ? hi : lo);
            check("we_n", sram_we_n, (wr && j < W) ? 0 : 1);
            check("oe", sram_dq_oe, wr);
            if (wr)
                check("dq_out", sram_dq_out, (ph != 0) ? d[31:16] : d[15:0]);
            check("freeze_busy", freeze, 1);
            check("ready_busy", ready, 0);
        end
        if (wr) begin
            exp_mem[lo] = d[15:0];
            exp_mem[hi] = d[31:16];
        end else begin
            exp_rd = {exp_mem[hi], exp_mem[lo]};
        end
        @(negedge clk);
        check("ready_done", ready, 1);
        check("freeze_done", freeze, 0);
        check("we_n_done", sram_we_n, 1);
        check("oe_done", sram_dq_oe, 0);
        check("read_data", read_data, exp_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_freeze", freeze, 0);
            check("idle_ready", ready, 0);
            check("idle_we_n", sram_we_n, 1);
            check("idle_oe", sram_dq_oe, 0);
            check("idle_rdata", read_data, exp_rd);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [AW-1:0] a_lo, a_hi;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = 16'h0000;
            exp_mem[i]  = 16'h0000;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_freeze", freeze, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_rdata", read_data, 0);
        check("rst_addr", sram_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // Write then read back the same word
        txn(1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF);
        idle(1);
        txn(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        check("rd_deadbeef", read_data, 32'hDEAD_BEEF);
        idle(1);

        // Read immediately followed by a write; read result must survive
        txn(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        txn(1'b0, 1'b1, 32'h0000_0414, 32'hCAFE_F00D);
        check("b2b_keep", read_data, 32'hDEAD_BEEF);
        idle(2);

        // Reset in the first HIGH cycle of a write
        a_lo       = half_addr(32'h0000_0410, 1'b0);
        a_hi       = half_addr(32'h0000_0410, 1'b1);
        mem_write  = 1'b1;
        address    = 32'h0000_0410;
        write_data = 32'h1234_5678;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_we_low", sram_we_n, 0);
        check("abort_addr_hi", sram_addr, a_hi);
        rst_n     = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("abort_we_n", sram_we_n, 1);
        check("abort_oe", sram_dq_oe, 0);
        check("abort_ready", ready, 0);
        check("abort_rdata", read_data, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        exp_rd = 32'h0;
        idle(10);
        check("abort_lo_written", sram_mem[a_lo], 16'h5678);
        check("abort_hi_kept", sram_mem[a_hi], exp_mem[a_hi]);
        exp_mem[a_lo] = 16'h5678;
        txn(1'b1, 1'b0, 32'h0000_0410, 32'h0);

        // Both strobes: write wins
        txn(1'b1, 1'b1, 32'h0000_040C, 32'h0BAD_CAFE);
        idle(1);
        txn(1'b1, 1'b0, 32'h0000_040C, 32'h0);
        check("both_is_write", read_data, 32'h0BAD_CAFE);

        // Address below the base wraps to the top of the SRAM
        txn(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_5A5A);
        txn(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        check("wrap_rd", read_data, 32'hA5A5_5A5A);

        // Random mix over a small address pool plus occasional far addresses
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0)
                a = $urandom;
            else
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            txn(op != 1, op != 0, a, $urandom);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
